proc_ctrl_fsm: RTL and testbench

Multi-cycle control unit for the 16-bit bus processor. Fetches each instruction through the memory port, latches it in an internal instruction register, then drives the 11-bit one-hot bus-source select, register load enables, ALU control and memory strobes to execute it. Sits beside the bus multiplexer and register file and is the only driver of their control inputs.

---
 rtl/proc_ctrl_pkg.sv | 34 +++
 rtl/proc_ctrl_fsm_dec3to8.sv | 12 +
 rtl/proc_ctrl_fsm.sv | 160 ++++++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the multi-cycle processor control unit:
// opcodes, FSM state encoding and bus-source select bit positions.
package proc_ctrl_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        F_ADDR,
        F_WAIT,
        F_IR,
        T1,
        T2,
        T3
    } state_t;

    localparam int SEL_MEM = 0;
    localparam int SEL_G   = 1;
    localparam int SEL_R0  = 2;
    localparam int SEL_R7  = 9;
    localparam int SEL_DIN = 10;

    function automatic logic is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/proc_ctrl_fsm_dec3to8.sv
// 3-bit register index to 8-bit one-hot decoder.
module dec3to8 (
    input  logic [2:0] idx,
    output logic [7:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle fetch/execute control unit for the 16-bit bus processor.
// Define PROC_CTRL_MVNZ_EN to execute opcode 110 as mvnz; otherwise it is a nop.
module proc_ctrl_fsm
    import proc_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] din,
    input  logic        mem_ready,
    input  logic        g_nz,
    output logic [10:0] bus_sel,
    output logic [7:0]  r_in,
    output logic        a_in,
    output logic        g_in,
    output logic        alu_sub,
    output logic        addr_in,
    output logic        dout_in,
    output logic        w_d,
    output logic        pc_inc,
    output logic        done
);

`ifdef PROC_CTRL_MVNZ_EN
    localparam logic MVNZ_EN = 1'b1;
`else
    localparam logic MVNZ_EN = 1'b0;
`endif

    state_t     state;
    logic [8:0] ir;
    logic [2:0] op;
    logic [2:0] sel_idx;
    logic       sel_use_x;
    logic       use_reg;
    logic [7:0] dec_x;
    logic [7:0] dec_sel;
    logic       unused_bits;

    assign op          = ir[8:6];
    assign unused_bits = ^{din[15:9], g_nz};

    // Only the first operand read of add/sub and the store data phase source R[X].
    assign sel_use_x = ((state == T1) && is_alu(op)) || ((state == T2) && (op == OP_ST));
    assign sel_idx   = sel_use_x ? ir[5:3] : ir[2:0];

    dec3to8 u_dec_x (
        .idx    (ir[5:3]),
        .onehot (dec_x)
    );

    dec3to8 u_dec_sel (
        .idx    (sel_idx),
        .onehot (dec_sel)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            case (state)
                IDLE:   if (run) state <= F_ADDR;
                F_ADDR: state <= F_WAIT;
                F_WAIT: if (mem_ready) state <= F_IR;
                F_IR: begin
                    ir    <= din[8:0];
                    state <= T1;
                end
                T1: begin
                    if (done) state <= run ? F_ADDR : IDLE;
                    else      state <= T2;
                end
                T2: begin
                    if (done)                          state <= run ? F_ADDR : IDLE;
                    else if (is_alu(op) || mem_ready)  state <= T3;
                end
                T3:      state <= run ? F_ADDR : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus_sel          = '0;
        r_in             = '0;
        a_in             = 1'b0;
        g_in             = 1'b0;
        alu_sub          = 1'b0;
        addr_in          = 1'b0;
        dout_in          = 1'b0;
        w_d              = 1'b0;
        pc_inc           = 1'b0;
        done             = 1'b0;
        use_reg          = 1'b0;
        // din is a bus source for the datapath but this sequence never selects it
        bus_sel[SEL_DIN] = 1'b0;

        case (state)
            F_ADDR: begin
                bus_sel[SEL_R7] = 1'b1;
                addr_in         = 1'b1;
                pc_inc          = 1'b1;
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        use_reg = 1'b1;
                        r_in    = dec_x;
                        done    = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel[SEL_R7] = 1'b1;
                        addr_in         = 1'b1;
                        pc_inc          = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        use_reg = 1'b1;
                        a_in    = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        use_reg = 1'b1;
                        addr_in = 1'b1;
                    end
                    OP_MVNZ: begin
                        done = 1'b1;
                        if (MVNZ_EN && g_nz) begin
                            use_reg = 1'b1;
                            r_in    = dec_x;
                        end
                    end
                    OP_NOP:  done = 1'b1;
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                if (is_alu(op)) begin
                    use_reg = 1'b1;
                    g_in    = 1'b1;
                    alu_sub = op[0];
                end else if (op == OP_ST) begin
                    use_reg = 1'b1;
                    dout_in = 1'b1;
                    w_d     = 1'b1;
                    done    = mem_ready;
                end
            end
            T3: begin
                if (is_alu(op)) bus_sel[SEL_G]   = 1'b1;
                else            bus_sel[SEL_MEM] = 1'b1;
                r_in = dec_x;
                done = 1'b1;
            end
            default: ;
        endcase

        if (use_reg) bus_sel[SEL_R0 +: 8] = dec_sel;
    end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed self-checking bench for proc_ctrl_fsm.
module tb_proc_ctrl_fsm;
    import proc_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [15:0] din = '0;
    logic        mem_ready = 1'b0;
    logic        g_nz = 1'b0;
    logic [10:0] bus_sel;
    logic [7:0]  r_in;
    logic        a_in, g_in, alu_sub, addr_in, dout_in, w_d, pc_inc, done;
    logic [26:0] outs;

    int compared = 0;
    int mismatched = 0;

    // flag byte order: a_in g_in alu_sub addr_in dout_in w_d pc_inc done
    localparam logic [7:0] FL_A    = 8'h80;
    localparam logic [7:0] FL_G    = 8'h40;
    localparam logic [7:0] FL_SUB  = 8'h20;
    localparam logic [7:0] FL_ADDR = 8'h10;
    localparam logic [7:0] FL_DOUT = 8'h08;
    localparam logic [7:0] FL_WD   = 8'h04;
    localparam logic [7:0] FL_PC   = 8'h02;
    localparam logic [7:0] FL_DONE = 8'h01;
    localparam logic [10:0] B_R7   = 11'b010_0000_0000;
    localparam logic [10:0] B_G    = 11'b000_0000_0010;
    localparam logic [10:0] B_MEM  = 11'b000_0000_0001;
    localparam logic [26:0] E_FADDR = {B_R7, 8'h00, 8'h12};

    always #5 clock = ~clock;

    proc_ctrl_fsm dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .din       (din),
        .mem_ready (mem_ready),
        .g_nz      (g_nz),
        .bus_sel   (bus_sel),
        .r_in      (r_in),
        .a_in      (a_in),
        .g_in      (g_in),
        .alu_sub   (alu_sub),
        .addr_in   (addr_in),
        .dout_in   (dout_in),
        .w_d       (w_d),
        .pc_inc    (pc_inc),
        .done      (done)
    );

    assign outs = {bus_sel, r_in, a_in, g_in, alu_sub, addr_in, dout_in, w_d, pc_inc, done};

    function automatic logic [26:0] ev(input logic [10:0] b, input logic [7:0] r, input logic [7:0] f);
        return {b, r, f};
    endfunction

    function automatic logic [10:0] br(input int k);
        return 11'(1) << (2 + k);
    endfunction

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        compared++;
        if (outs !== '0) begin
            mismatched++;
            $display("FAIL reset_outs: got %h expected %h", outs, 27'h0);
        end
        compared++;
        if (dut.ir !== 9'h000) begin
            mismatched++;
            $display("FAIL reset_ir: got %h expected %h", dut.ir, 9'h000);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        compared++;
        if (dut.state !== IDLE) begin
            mismatched++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
        end
    endtask

    task automatic test_mv();
        logic [26:0] exp[5];
        exp = '{E_FADDR, '0, '0, ev(br(5), 8'b0000_1000, FL_DONE), '0};
        din = 16'h001D;
        mem_ready = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i == 0) run = 1'b0;
            #1;
            compared++;
            if (outs !== exp[i]) begin
                mismatched++;
                $display("FAIL mv step %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_add_sub();
        logic [26:0] exp[6];
        exp = '{E_FADDR, '0, '0, ev(br(1), 8'h00, FL_A), ev(br(2), 8'h00, FL_G),
                ev(B_G, 8'b0000_0010, FL_DONE)};
        din = 16'h008A;
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 0) run = 1'b0;
            #1;
            compared++;
            if (outs !== exp[i]) begin
                mismatched++;
                $display("FAIL add step %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
        exp = '{E_FADDR, '0, '0, ev(br(4), 8'h00, FL_A), ev(br(6), 8'h00, FL_G | FL_SUB),
                ev(B_G, 8'b0001_0000, FL_DONE)};
        @(negedge clock);
        din = 16'h00E6;
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 0) run = 1'b0;
            #1;
            compared++;
            if (outs !== exp[i]) begin
                mismatched++;
                $display("FAIL sub step %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_ld_wait();
        logic [26:0] exp[10];
        logic        mr[10];
        exp = '{E_FADDR, '0, '0, ev(br(4), 8'h00, FL_ADDR), '0, '0, '0, '0,
                ev(B_MEM, 8'b0000_0001, FL_DONE), '0};
        mr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        din = 16'h0104;
        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i == 0) run = 1'b0;
            mem_ready = mr[i];
            #1;
            compared++;
            if (outs !== exp[i]) begin
                mismatched++;
                $display("FAIL ld step %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_st_wait();
        logic [26:0] exp[8];
        logic        mr[8];
        exp = '{E_FADDR, '0, '0, ev(br(2), 8'h00, FL_ADDR),
                ev(br(6), 8'h00, FL_DOUT | FL_WD), ev(br(6), 8'h00, FL_DOUT | FL_WD),
                ev(br(6), 8'h00, FL_DOUT | FL_WD | FL_DONE), '0};
        mr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        din = 16'h0172;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (i == 0) run = 1'b0;
            mem_ready = mr[i];
            #1;
            compared++;
            if (outs !== exp[i]) begin
                mismatched++;
                $display("FAIL st step %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_mvi_fetch_wait();
        logic [26:0] exp[9];
        logic        mr[9];
        exp = '{E_FADDR, '0, '0, '0, '0, ev(B_R7, 8'h00, FL_ADDR | FL_PC), '0,
                ev(B_MEM, 8'b1000_0000, FL_DONE), '0};
        mr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        din = 16'h0078;
        run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (i == 0) run = 1'b0;
            mem_ready = mr[i];
            #1;
            compared++;
            if (outs !== exp[i]) begin
                mismatched++;
                $display("FAIL mvi step %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_mvnz();
        logic [26:0] exp[5];
        mem_ready = 1'b1;
        for (int g = 0; g < 2; g++) begin
            exp = '{E_FADDR, '0, '0, ev(11'h000, 8'h00, FL_DONE), '0};
`ifdef PROC_CTRL_MVNZ_EN
            if (g == 1) exp[3] = ev(br(3), 8'b0000_0100, FL_DONE);
`endif
            g_nz = (g == 1);
            din = 16'h0193;
            run = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                if (i == 0) run = 1'b0;
                #1;
                compared++;
                if (outs !== exp[i]) begin
                    mismatched++;
                    $display("FAIL mvnz g_nz=%0d step %0d: got %h expected %h", g, i, outs, exp[i]);
                end
            end
        end
        g_nz = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [26:0] exp[9];
        logic [15:0] dv[9];
        logic        rv[9];
        exp = '{E_FADDR, '0, '0, ev(br(5), 8'b0000_1000, FL_DONE),
                E_FADDR, '0, '0, ev(11'h000, 8'h00, FL_DONE), '0};
        dv  = '{16'h001D, 16'h001D, 16'h001D, 16'h001D, 16'h01C0, 16'h01C0, 16'h01C0, 16'h01C0, 16'h01C0};
        rv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        mem_ready = 1'b1;
        din = dv[0];
        run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            run = rv[i];
            din = dv[i];
            #1;
            compared++;
            if (outs !== exp[i]) begin
                mismatched++;
                $display("FAIL b2b step %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_add();
        logic [26:0] exp[5];
        exp = '{E_FADDR, '0, '0, ev(br(1), 8'h00, FL_A), ev(br(2), 8'h00, FL_G)};
        mem_ready = 1'b1;
        din = 16'h008A;
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            compared++;
            if (outs !== exp[i]) begin
                mismatched++;
                $display("FAIL rst_add step %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
        #1 reset = 1'b1;
        #1;
        compared++;
        if (outs !== '0) begin
            mismatched++;
            $display("FAIL rst_mid_outs: got %h expected %h", outs, 27'h0);
        end
        compared++;
        if (dut.ir !== 9'h000) begin
            mismatched++;
            $display("FAIL rst_mid_ir: got %h expected %h", dut.ir, 9'h000);
        end
        compared++;
        if (dut.state !== IDLE) begin
            mismatched++;
            $display("FAIL rst_mid_state: got %0d expected %0d", dut.state, IDLE);
        end
        @(posedge clock);
        #1;
        compared++;
        if (r_in !== 8'h00) begin
            mismatched++;
            $display("FAIL rst_mid_rin: got %h expected %h", r_in, 8'h00);
        end
        @(negedge clock);
        run = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        #1;
        compared++;
        if (outs !== '0) begin
            mismatched++;
            $display("FAIL rst_mid_idle: got %h expected %h", outs, 27'h0);
        end
    endtask

    initial begin
        test_reset();
        test_mv();
        test_add_sub();
        test_ld_wait();
        test_st_wait();
        test_mvi_fetch_wait();
        test_mvnz();
        test_back_to_back();
        test_reset_mid_add();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
